// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry {addr, inst} holding register that catches a response while decode is stalled.
module if_skid_buffer (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_inst,
  output logic        o_full,
  output logic [31:0] o_addr,
  output logic [31:0] o_inst
);

  logic        r_full;
  logic [31:0] r_addr;
  logic [31:0] r_inst;

  // A load in the same cycle as an unload refills the entry.
  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_addr <= 32'h0000_0000;
      r_inst <= 32'h0000_0000;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_inst <= i_inst;
    end else begin
      r_addr <= r_addr;
      r_inst <= r_inst;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_inst = r_inst;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, single-outstanding instruction bus master, skid buffer and IF_ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = RV32I_NOP
) (
  input  logic        clk,
  input  logic        rst_sync,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        trap_en,
  input  logic [31:0] trap_addr,
  input  logic        stall_if,
  input  logic        flush_if,
  output logic [31:0] instruction_addr_if_id,
  output logic [31:0] instruction_if_id,
  output logic        inst_valid_if_id
);

  if_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_resp_pc;
  logic [31:0] r_if_addr;
  logic [31:0] r_if_inst;
  logic        r_if_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_resp;
  logic        w_skid_load;
  logic        w_skid_unload;
  logic        w_skid_clear;
  logic        w_skid_empty_next;
  logic        w_skid_full;
  logic [31:0] w_skid_addr;
  logic [31:0] w_skid_inst;
  logic        w_req;
  logic        w_take;
  logic        w_outstanding_next;

  // Redirect decode, skid routing and the combinational request (rvalid->req path).
  always_comb begin
    w_redirect    = trap_en || jump_en;
    w_target      = trap_en ? trap_addr : jump_addr;
    w_resp        = (r_state == WAIT) && ibus_rvalid;
    w_skid_clear  = w_redirect || flush_if;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    if (w_skid_clear) begin
      w_skid_load   = 1'b0;
      w_skid_unload = 1'b0;
    end else if (stall_if) begin
      w_skid_load   = w_resp && !w_skid_full;
      w_skid_unload = 1'b0;
    end else begin
      w_skid_unload = w_skid_full;
      w_skid_load   = w_resp && w_skid_full;
    end
    w_skid_empty_next = w_skid_clear ||
                        !(w_skid_load || (w_skid_full && !w_skid_unload));
    case (r_state)
      FETCH:   w_req = !w_skid_full;
      WAIT:    w_req = ibus_rvalid && w_skid_empty_next;
      default: w_req = 1'b0;
    endcase
    ibus_req = w_req && !rst_sync;
    w_take   = ibus_req && ibus_gnt;
    // A gnt during a redirect still leaves a response in flight that must be dropped.
    w_outstanding_next = ((r_state != FETCH) && !ibus_rvalid) || w_take;
  end

  assign ibus_addr = r_pc & 32'hFFFF_FFFC;

  // PC, response PC and fetch state machine.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_pc      <= RESET_VECTOR;
      r_resp_pc <= RESET_VECTOR;
      r_state   <= FETCH;
    end else if (w_redirect) begin
      r_pc      <= w_target & 32'hFFFF_FFFC;
      r_resp_pc <= r_resp_pc;
      r_state   <= w_outstanding_next ? DISCARD : FETCH;
    end else begin
      if (w_take) begin
        r_pc      <= r_pc + 32'd4;
        r_resp_pc <= r_pc;
      end else begin
        r_pc      <= r_pc;
        r_resp_pc <= r_resp_pc;
      end
      case (r_state)
        FETCH:   r_state <= w_take ? WAIT : FETCH;
        WAIT:    r_state <= ibus_rvalid ? (w_take ? WAIT : FETCH) : WAIT;
        DISCARD: r_state <= ibus_rvalid ? FETCH : DISCARD;
        default: r_state <= FETCH;
      endcase
    end
  end

  // IF_ID register: the skid entry is older than any response, so it drains first.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_if_addr  <= RESET_VECTOR;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else if (w_redirect || flush_if) begin
      r_if_addr  <= r_if_addr;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else if (stall_if) begin
      r_if_addr  <= r_if_addr;
      r_if_inst  <= r_if_inst;
      r_if_valid <= r_if_valid;
    end else if (w_skid_full) begin
      r_if_addr  <= w_skid_addr;
      r_if_inst  <= w_skid_inst;
      r_if_valid <= 1'b1;
    end else if (w_resp) begin
      r_if_addr  <= r_resp_pc;
      r_if_inst  <= ibus_rdata;
      r_if_valid <= 1'b1;
    end else begin
      r_if_addr  <= r_if_addr;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end
  end

  if_skid_buffer u_skid (
    .clk      (clk),
    .i_rst    (rst_sync),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_addr   (r_resp_pc),
    .i_inst   (ibus_rdata),
    .o_full   (w_skid_full),
    .o_addr   (w_skid_addr),
    .o_inst   (w_skid_inst)
  );

  assign instruction_addr_if_id = r_if_addr;
  assign instruction_if_id      = r_if_inst;
  assign inst_valid_if_id       = r_if_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a variable-latency memory model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_sync, ibus_req, ibus_gnt, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_rdata;
  logic        jump_en, trap_en, stall_if, flush_if;
  logic [31:0] jump_addr, trap_addr;
  logic [31:0] if_addr, if_inst;
  logic        if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: one request in flight, response 'lat' cycles after gnt, data = address.
  logic        gnt_en, poison_on, mem_busy;
  int          lat, mem_cnt;
  logic [31:0] mem_q;

  assign ibus_gnt    = ibus_req && gnt_en && (!mem_busy || ibus_rvalid);
  assign ibus_rvalid = mem_busy && (mem_cnt == 1);
  assign ibus_rdata  = (poison_on && mem_q == 32'h0) ? 32'h0000_DEAD : mem_q;

  always @(posedge clk) begin
    if (rst_sync) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
    end else if (ibus_gnt) begin
      mem_busy <= 1'b1;
      mem_cnt  <= lat;
      mem_q    <= ibus_addr;
    end else if (ibus_rvalid) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk                    (clk),
    .rst_sync               (rst_sync),
    .ibus_req               (ibus_req),
    .ibus_addr              (ibus_addr),
    .ibus_gnt               (ibus_gnt),
    .ibus_rvalid            (ibus_rvalid),
    .ibus_rdata             (ibus_rdata),
    .jump_en                (jump_en),
    .jump_addr              (jump_addr),
    .trap_en                (trap_en),
    .trap_addr              (trap_addr),
    .stall_if               (stall_if),
    .flush_if               (flush_if),
    .instruction_addr_if_id (if_addr),
    .instruction_if_id      (if_inst),
    .inst_valid_if_id       (if_valid)
  );

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ia;
    logic [31:0] inst;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Leaves the bench just after a negedge with reset released: next posedge ends cycle 0.
  task automatic do_reset(input int l);
    @(negedge clk);
    rst_sync = 1'b1; jump_en = 1'b0; trap_en = 1'b0; stall_if = 1'b0; flush_if = 1'b0;
    jump_addr = 32'h0; trap_addr = 32'h0; gnt_en = 1'b1; poison_on = 1'b0; lat = l;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(ibus_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_addr", if_addr, 32'h0);
    @(negedge clk);
    rst_sync = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      stall_if = vecs[i].stall;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(ibus_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), ibus_addr, vecs[i].addr);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_ifaddr", i), if_addr, vecs[i].ia);
      chk($sformatf("vec%0d_inst", i), if_inst, vecs[i].inst);
      @(negedge clk);
    end
    stall_if = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    int n = 0;
    #1;
    while (!ibus_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (ibus_req) chk(name, ibus_addr, exp);
    else timeout(name);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!if_valid && n < 40);
    if (if_valid) begin
      chk({name, "_addr"}, if_addr, exp);
      chk({name, "_inst"}, if_inst, exp);
    end else begin
      timeout(name);
    end
  endtask

  initial begin
    logic [31:0] exp_next, p_addr, p_inst, tgt;
    logic        p_valid, redir;
    int          n_rx;

    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h08};
    vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h0C};
    vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10, 32'h10};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'h10};
    vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'h10};
    vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'h10};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h14, 32'h14};
    vecs[10] = '{1'b0, 1'b1, 32'h18, 1'b0, 32'h14, NOP};
    vecs[11] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h18, 32'h18};

    // Streaming from reset plus a 3-cycle stall with skid capture.
    do_reset(1);
    run_rows(0, 11);

    // 3-cycle memory: a request only when the bus is idle or returning.
    do_reset(3);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("lat3_req%0d", i), 32'(ibus_req), 32'(!mem_busy || ibus_rvalid));
      @(negedge clk);
    end

    // Jump while a poisoned response is outstanding.
    do_reset(3);
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 32'h200; poison_on = 1'b1;
    #1;
    chk("jmp_req_idle", 32'(ibus_req), 32'h0);
    @(posedge clk); #1;
    chk("jmp_bubble_valid", 32'(if_valid), 32'h0);
    chk("jmp_bubble_inst", if_inst, NOP);
    @(negedge clk);
    jump_en = 1'b0;
    wait_req("jmp_fetch_addr", 32'h200);
    wait_valid("jmp_first", 32'h200);
    poison_on = 1'b0;

    // Trap beats jump; low target bits are ignored.
    do_reset(1);
    trap_en = 1'b1; trap_addr = 32'h103; jump_en = 1'b1; jump_addr = 32'h200;
    @(negedge clk);
    trap_en = 1'b0; jump_en = 1'b0;
    wait_req("trap_fetch_addr", 32'h100);
    wait_valid("trap_first", 32'h100);

    // Flush with skid full: both entries dropped, PC continues.
    do_reset(1);
    run_rows(0, 7);
    flush_if = 1'b1;
    #1;
    chk("flush_req", 32'(ibus_req), 32'h0);
    @(posedge clk); #1;
    chk("flush_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    flush_if = 1'b0;
    wait_valid("flush_next", 32'h18);

    // Random stalls, gnt jitter, latency and redirects against an ordered-stream model.
    do_reset(1);
    exp_next = 32'h0;
    n_rx = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_if  = ($urandom_range(0, 3) == 0);
      gnt_en    = ($urandom_range(0, 3) != 0);
      lat       = int'($urandom_range(1, 4));
      jump_en   = ($urandom_range(0, 49) == 0);
      trap_en   = ($urandom_range(0, 99) == 0);
      jump_addr = 32'($urandom_range(0, 1023));
      trap_addr = 32'($urandom_range(0, 1023)) | 32'h0000_1000;
      redir     = jump_en || trap_en;
      tgt       = trap_en ? trap_addr : jump_addr;
      p_valid = if_valid; p_addr = if_addr; p_inst = if_inst;
      @(posedge clk); #1;
      if (redir) begin
        chk("rnd_redirect_bubble", 32'(if_valid), 32'h0);
        exp_next = tgt & 32'hFFFF_FFFC;
      end else if (stall_if) begin
        chk("rnd_stall_hold", {31'h0, if_valid} ^ if_addr ^ {if_inst[15:0], if_inst[31:16]},
            {31'h0, p_valid} ^ p_addr ^ {p_inst[15:0], p_inst[31:16]});
      end else if (if_valid) begin
        chk("rnd_order", if_addr, exp_next);
        chk("rnd_data", if_inst, if_addr);
        exp_next = exp_next + 32'd4;
        n_rx++;
      end
      @(negedge clk);
    end
    jump_en = 1'b0; trap_en = 1'b0; stall_if = 1'b0; gnt_en = 1'b1;
    chk("rnd_progress", 32'(n_rx > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
